load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/load_align.sv | 29 ++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Purpose: shared encodings for the load/store unit: access sizes, FSM states,
//          lane-mask constants and a lane-mask helper.
// Contents: SIZE_* access size codes, lsu_state_e, LANE_* masks, lane_mask().
package mem_pkg;

  localparam int unsigned XLEN = 32;

  // accessSize encodings; SIZE_RSVD behaves as a word access
  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } lsu_state_e;

  // Little-endian lane masks within a 32-bit word
  localparam logic [XLEN-1:0] LANE_BYTE0 = 32'h0000_00FF;
  localparam logic [XLEN-1:0] LANE_BYTE1 = 32'h0000_FF00;
  localparam logic [XLEN-1:0] LANE_BYTE2 = 32'h00FF_0000;
  localparam logic [XLEN-1:0] LANE_BYTE3 = 32'hFF00_0000;
  localparam logic [XLEN-1:0] LANE_HALF0 = 32'h0000_FFFF;
  localparam logic [XLEN-1:0] LANE_HALF1 = 32'hFFFF_0000;
  localparam logic [XLEN-1:0] LANE_WORD  = 32'hFFFF_FFFF;

  // Mask of the bits written by a store of the given size at the given offset
  function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
    logic [XLEN-1:0] m;
    m = LANE_WORD;
    case (size)
      SIZE_BYTE: begin
        case (addr_lo)
          2'd0:    m = LANE_BYTE0;
          2'd1:    m = LANE_BYTE1;
          2'd2:    m = LANE_BYTE2;
          default: m = LANE_BYTE3;
        endcase
      end
      SIZE_HALF: m = addr_lo[1] ? LANE_HALF1 : LANE_HALF0;
      default:   m = LANE_WORD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Purpose: extract the addressed lane from a memory word and sign/zero extend it.
// Ports: word_i (memory word), addr_lo_i (byte offset), size_i (access size),
//        unsigned_i (1 = zero extend), data_o (aligned, extended result).
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = word_i;
    case (size_i)
      SIZE_BYTE: data_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SIZE_HALF: data_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default:   data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: CPU-side load/store unit in front of a word-only data memory.
//          Word stores and all loads complete in zero latency; byte/half stores
//          do a one-stall read-modify-write through mergeBuf.
// Ports: clk, reset (async active-high); CPU side memRead, memWrite, accessSize,
//        loadUnsigned, address, storeData, loadData, stall, addrError, rmwCount;
//        memory side dmemRead, dmemWrite, dmemAddress, dmemWriteData, dmemReadData.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int unsigned RMW_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic [1:0]           accessSize,
  input  logic                 loadUnsigned,
  input  logic [31:0]          address,
  input  logic [31:0]          storeData,
  output logic [31:0]          loadData,
  output logic                 stall,
  output logic                 addrError,
  output logic [RMW_CNT_W-1:0] rmwCount,
  output logic                 dmemRead,
  output logic                 dmemWrite,
  output logic [31:0]          dmemAddress,
  output logic [31:0]          dmemWriteData,
  input  logic [31:0]          dmemReadData
);

  lsu_state_e           state_q, state_d;
  logic [XLEN-1:0]      merge_buf_q, merge_buf_d;
  logic                 addr_err_q, addr_err_d;
  logic [RMW_CNT_W-1:0] rmw_cnt_q, rmw_cnt_d;

  logic            is_half, is_byte, sub_word, any_acc, is_store, misaligned, valid_acc;
  logic            rmw_start, load_valid, rd_raw, wr_raw, stall_raw;
  logic [XLEN-1:0] aligned, merged, store_rep, wdata;

  // Access decode; both strobes high counts as a store
  assign is_half    = (accessSize == SIZE_HALF);
  assign is_byte    = (accessSize == SIZE_BYTE);
  assign sub_word   = is_half | is_byte;
  assign any_acc    = memRead | memWrite;
  assign is_store   = memWrite;
  assign misaligned = sub_word ? (is_half & address[0]) : (address[1:0] != 2'b00);
  assign valid_acc  = any_acc & ~misaligned;
  assign rmw_start  = (state_q == ST_IDLE) & valid_acc & is_store & sub_word;

  // Replace only the addressed lane of the buffered word
  assign store_rep = is_byte ? {4{storeData[7:0]}} : {2{storeData[15:0]}};
  assign merged    = (merge_buf_q & ~lane_mask(accessSize, address[1:0]))
                   | (store_rep & lane_mask(accessSize, address[1:0]));

  load_align u_load_align (
    .word_i     (dmemReadData),
    .addr_lo_i  (address[1:0]),
    .size_i     (accessSize),
    .unsigned_i (loadUnsigned),
    .data_o     (aligned)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rmw_start) state_d = ST_MERGE;
      ST_MERGE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    rd_raw     = 1'b0;
    wr_raw     = 1'b0;
    stall_raw  = 1'b0;
    load_valid = 1'b0;
    wdata      = storeData;
    case (state_q)
      ST_IDLE: begin
        if (valid_acc) begin
          if (is_store && sub_word) begin
            rd_raw    = 1'b1;
            stall_raw = 1'b1;
          end else if (is_store) begin
            wr_raw = 1'b1;
          end else begin
            rd_raw     = 1'b1;
            load_valid = 1'b1;
          end
        end
      end
      ST_MERGE: begin
        wr_raw = 1'b1;
        wdata  = merged;
      end
      default: ;
    endcase
  end

  // Datapath register updates
  always_comb begin
    merge_buf_d = rmw_start ? dmemReadData : merge_buf_q;
    addr_err_d  = addr_err_q | ((state_q == ST_IDLE) & any_acc & misaligned);
    rmw_cnt_d   = rmw_cnt_q;
    if ((state_q == ST_MERGE) && (rmw_cnt_q != '1)) rmw_cnt_d = rmw_cnt_q + RMW_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      merge_buf_q <= '0;
      addr_err_q  <= 1'b0;
      rmw_cnt_q   <= '0;
    end else begin
      merge_buf_q <= merge_buf_d;
      addr_err_q  <= addr_err_d;
      rmw_cnt_q   <= rmw_cnt_d;
    end
  end

  // Memory strobes and stall are killed while reset is high
  assign dmemRead      = rd_raw & ~reset;
  assign dmemWrite     = wr_raw & ~reset;
  assign stall         = stall_raw & ~reset;
  assign dmemAddress   = {address[31:2], 2'b00};
  assign dmemWriteData = wdata;
  assign loadData      = (load_valid & ~reset) ? aligned : 32'h0;
  assign addrError     = addr_err_q;
  assign rmwCount      = rmw_cnt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory
// written on the falling clock edge.
module tb_load_store_unit;

  localparam logic [1:0] SW = 2'd0;
  localparam logic [1:0] SH = 2'd1;
  localparam logic [1:0] SB = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite, loadUnsigned;
  logic [1:0]  accessSize;
  logic [31:0] address, storeData, loadData;
  logic        stall, addrError;
  logic [3:0]  rmwCount;
  logic        dmemRead, dmemWrite;
  logic [31:0] dmemAddress, dmemWriteData, dmemReadData;

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.RMW_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .accessSize(accessSize), .loadUnsigned(loadUnsigned), .address(address),
    .storeData(storeData), .loadData(loadData), .stall(stall), .addrError(addrError),
    .rmwCount(rmwCount), .dmemRead(dmemRead), .dmemWrite(dmemWrite),
    .dmemAddress(dmemAddress), .dmemWriteData(dmemWriteData), .dmemReadData(dmemReadData)
  );

  assign dmemReadData = mem[dmemAddress[9:2]];

  always @(negedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (dmemWrite) mem[dmemAddress[9:2]] <= dmemWriteData;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] d);
    memRead = rd; memWrite = wr; accessSize = sz; loadUnsigned = uns;
    address = a; storeData = d;
  endtask

  task automatic idle();
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_idx = idx; pl_val = val; pl_en = 1'b1;
    @(negedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, SW, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (rmwCount !== 4'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", rmwCount); end
    checks++; if (addrError !== 1'b0) begin errors++; $display("FAIL reset_aerr got %b exp 0", addrError); end
    checks++; if (loadData !== 32'h0) begin errors++; $display("FAIL reset_ldata got %h exp 0", loadData); end
    drive(1'b0, 1'b1, SB, 1'b0, 32'h100, 32'h12);
    #1;
    checks++; if ({dmemWrite, dmemRead, stall} !== 3'b000) begin errors++; $display("FAIL reset_gate got %b exp 000", {dmemWrite, dmemRead, stall}); end
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_no_access();
    tick();
    drive(1'b0, 1'b0, SW, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if ({dmemWrite, dmemRead, stall} !== 3'b000) begin errors++; $display("FAIL noacc_strobes got %b exp 000", {dmemWrite, dmemRead, stall}); end
    checks++; if (loadData !== 32'h0) begin errors++; $display("FAIL noacc_ldata got %h exp 0", loadData); end
  endtask

  task automatic test_byte_store();
    preload(8'h40, 32'h1122_3344);
    tick();
    drive(1'b0, 1'b1, SB, 1'b0, 32'h102, 32'hAB);
    #1;
    checks++; if ({stall, dmemRead, dmemWrite} !== 3'b110) begin errors++; $display("FAIL bs_read got %b exp 110", {stall, dmemRead, dmemWrite}); end
    checks++; if (dmemAddress !== 32'h100) begin errors++; $display("FAIL bs_addr got %h exp 00000100", dmemAddress); end
    tick();
    checks++; if ({stall, dmemWrite} !== 2'b01) begin errors++; $display("FAIL bs_merge_strobe got %b exp 01", {stall, dmemWrite}); end
    checks++; if (dmemWriteData !== 32'h11AB_3344) begin errors++; $display("FAIL bs_wdata got %h exp 11ab3344", dmemWriteData); end
    tick();
    idle();
    #1;
    checks++; if (rmwCount !== 4'h1) begin errors++; $display("FAIL bs_cnt got %h exp 1", rmwCount); end
    checks++; if (mem[8'h40] !== 32'h11AB_3344) begin errors++; $display("FAIL bs_mem got %h exp 11ab3344", mem[8'h40]); end
    drive(1'b1, 1'b0, SW, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (loadData !== 32'h11AB_3344) begin errors++; $display("FAIL bs_readback got %h exp 11ab3344", loadData); end
    idle();
  endtask

  task automatic test_load_extend();
    preload(8'h40, 32'h80FF_0000);
    drive(1'b1, 1'b0, SB, 1'b0, 32'h103, 32'h0);
    #1;
    checks++; if (loadData !== 32'hFFFF_FF80) begin errors++; $display("FAIL ld_b3_s got %h exp ffffff80", loadData); end
    checks++; if ({dmemRead, dmemWrite, stall} !== 3'b100) begin errors++; $display("FAIL ld_strobes got %b exp 100", {dmemRead, dmemWrite, stall}); end
    loadUnsigned = 1'b1; #1;
    checks++; if (loadData !== 32'h0000_0080) begin errors++; $display("FAIL ld_b3_u got %h exp 00000080", loadData); end
    address = 32'h102; #1;
    checks++; if (loadData !== 32'h0000_00FF) begin errors++; $display("FAIL ld_b2_u got %h exp 000000ff", loadData); end
    accessSize = SH; loadUnsigned = 1'b0; #1;
    checks++; if (loadData !== 32'hFFFF_80FF) begin errors++; $display("FAIL ld_h1_s got %h exp ffff80ff", loadData); end
    accessSize = 2'd3; address = 32'h100; #1;
    checks++; if (loadData !== 32'h80FF_0000) begin errors++; $display("FAIL ld_rsvd_word got %h exp 80ff0000", loadData); end
    idle();
  endtask

  task automatic test_half_store();
    preload(8'h40, 32'h1122_3344);
    tick();
    drive(1'b0, 1'b1, SH, 1'b0, 32'h102, 32'h0000_BEEF);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hs_stall got %b exp 1", stall); end
    tick();
    checks++; if (dmemWriteData !== 32'hBEEF_3344) begin errors++; $display("FAIL hs_wdata got %h exp beef3344", dmemWriteData); end
    tick();
    idle();
    #1;
    checks++; if (mem[8'h40] !== 32'hBEEF_3344) begin errors++; $display("FAIL hs_mem got %h exp beef3344", mem[8'h40]); end
    checks++; if (rmwCount !== 4'h2) begin errors++; $display("FAIL hs_cnt got %h exp 2", rmwCount); end
    drive(1'b1, 1'b0, SH, 1'b1, 32'h100, 32'h0);
    #1;
    checks++; if (loadData !== 32'h0000_3344) begin errors++; $display("FAIL hs_ld_lo_u got %h exp 00003344", loadData); end
    address = 32'h102; loadUnsigned = 1'b0; #1;
    checks++; if (loadData !== 32'hFFFF_BEEF) begin errors++; $display("FAIL hs_ld_hi_s got %h exp ffffbeef", loadData); end
    idle();
  endtask

  task automatic test_word_store();
    tick();
    drive(1'b0, 1'b1, SW, 1'b0, 32'h104, 32'hDEAD_BEEF);
    #1;
    checks++; if ({dmemWrite, dmemRead, stall} !== 3'b100) begin errors++; $display("FAIL ws_strobes got %b exp 100", {dmemWrite, dmemRead, stall}); end
    tick();
    drive(1'b1, 1'b1, SW, 1'b0, 32'h108, 32'hCAFE_F00D);
    #1;
    checks++; if ({dmemWrite, dmemRead} !== 2'b10) begin errors++; $display("FAIL both_strobes got %b exp 10", {dmemWrite, dmemRead}); end
    checks++; if (loadData !== 32'h0) begin errors++; $display("FAIL both_ldata got %h exp 0", loadData); end
    tick();
    idle();
    checks++; if (mem[8'h41] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_mem got %h exp deadbeef", mem[8'h41]); end
    checks++; if (mem[8'h42] !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_mem got %h exp cafef00d", mem[8'h42]); end
    checks++; if (rmwCount !== 4'h2) begin errors++; $display("FAIL ws_cnt got %h exp 2", rmwCount); end
  endtask

  task automatic test_misaligned();
    preload(8'h40, 32'h1122_3344);
    tick();
    drive(1'b0, 1'b1, SW, 1'b0, 32'h101, 32'h0000_0055);
    #1;
    checks++; if ({dmemWrite, dmemRead, stall} !== 3'b000) begin errors++; $display("FAIL mis_strobes got %b exp 000", {dmemWrite, dmemRead, stall}); end
    checks++; if (addrError !== 1'b0) begin errors++; $display("FAIL mis_aerr_early got %b exp 0", addrError); end
    tick();
    idle();
    checks++; if (addrError !== 1'b1) begin errors++; $display("FAIL mis_aerr got %b exp 1", addrError); end
    drive(1'b1, 1'b0, SH, 1'b0, 32'h103, 32'h0);
    #1;
    checks++; if ({loadData, dmemRead} !== 33'h0) begin errors++; $display("FAIL mis_load got %h/%b exp 0/0", loadData, dmemRead); end
    idle();
    tick(); tick();
    checks++; if (addrError !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b exp 1", addrError); end
    checks++; if (mem[8'h40] !== 32'h1122_3344) begin errors++; $display("FAIL mis_mem got %h exp 11223344", mem[8'h40]); end
  endtask

  task automatic test_reset_in_merge();
    do_reset();
    checks++; if ({addrError, rmwCount} !== 5'h0) begin errors++; $display("FAIL rim_clear got %b/%h exp 0/0", addrError, rmwCount); end
    preload(8'h40, 32'h1122_3344);
    tick();
    drive(1'b0, 1'b1, SB, 1'b0, 32'h102, 32'hAB);
    tick();
    checks++; if (dmemWrite !== 1'b1) begin errors++; $display("FAIL rim_in_merge got %b exp 1", dmemWrite); end
    reset = 1'b1;
    #1;
    checks++; if ({dmemWrite, stall} !== 2'b00) begin errors++; $display("FAIL rim_gate got %b exp 00", {dmemWrite, stall}); end
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    // Back in IDLE with the sub-word store still presented: must stall again
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rim_idle got %b exp 1", stall); end
    idle();
    tick();
    checks++; if (rmwCount !== 4'h0) begin errors++; $display("FAIL rim_cnt got %h exp 0", rmwCount); end
    checks++; if (mem[8'h40] !== 32'h1122_3344) begin errors++; $display("FAIL rim_mem got %h exp 11223344", mem[8'h40]); end
  endtask

  task automatic test_saturate();
    do_reset();
    preload(8'h50, 32'h0);
    for (int i = 0; i < 18; i++) begin
      tick();
      drive(1'b0, 1'b1, SB, 1'b0, 32'h140 + 32'(i % 4), 32'(i));
      tick();
      tick();
      idle();
      if (i == 9) begin
        checks++; if (rmwCount !== 4'hA) begin errors++; $display("FAIL sat_mid got %h exp a", rmwCount); end
      end
      if (i == 14) begin
        checks++; if (rmwCount !== 4'hF) begin errors++; $display("FAIL sat_full got %h exp f", rmwCount); end
      end
    end
    checks++; if (rmwCount !== 4'hF) begin errors++; $display("FAIL sat_hold got %h exp f", rmwCount); end
    // Last four byte stores: 14..17 into lanes 2,3,0,1
    checks++; if (mem[8'h50] !== 32'h0F0E_1110) begin errors++; $display("FAIL sat_mem got %h exp 0f0e1110", mem[8'h50]); end
  endtask

  initial begin
    test_reset();
    test_no_access();
    test_byte_store();
    test_load_extend();
    test_half_store();
    test_word_store();
    test_misaligned();
    test_reset_in_merge();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
